// File: rtl/cnn_conv_acc.sv
// Convolution accumulator: sums N_TERMS signed products plus a bias, then applies
// ReLU, round-half-up right shift and saturation to a signed activation.
module cnn_conv_acc #(
    parameter int PROD_W  = 22,
    parameter int BIAS_W  = 16,
    parameter int ACC_W   = 32,
    parameter int N_TERMS = 9,
    parameter int SHIFT   = 8,
    parameter int OUT_W   = 8
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [PROD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BIAS_W-1:0] bias,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic ONE_TERM = (N_TERMS == 1);
    localparam logic [ACC_W:0] RND_HALF = (ACC_W + 1)'(1) << (SHIFT - 1);
    localparam logic [ACC_W:0] OUT_MAX  = (ACC_W + 1)'((1 << (OUT_W - 1)) - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [OUT_W-1:0]   out_data_q;
    logic               out_valid_q;

    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   bias_ext;
    logic [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               last_term;
    logic [ACC_W:0]     rnd_w;
    logic [ACC_W:0]     q_w;
    logic [OUT_W-1:0]   out_d;

    assign prod_ext = {{(ACC_W - PROD_W){in_data[PROD_W-1]}}, in_data};
    assign bias_ext = {{(ACC_W - BIAS_W){bias[BIAS_W-1]}}, bias};

    // The first term of a group starts from the bias instead of the running sum.
    always_comb begin
        acc_d     = ((state_q == ST_IDLE) ? bias_ext : acc_q) + prod_ext;
        cnt_d     = (state_q == ST_IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
        last_term = (state_q == ST_IDLE) ? ONE_TERM : (cnt_q == CNT_W'(N_TERMS - 1));
    end

    // Requantize the value being loaded, so the result is ready on the edge entering OUT.
    always_comb begin
        rnd_w = acc_d[ACC_W-1] ? RND_HALF : ({1'b0, acc_d} + RND_HALF);
        q_w   = rnd_w >> SHIFT;
        out_d = (q_w > OUT_MAX) ? OUT_MAX[OUT_W-1:0] : q_w[OUT_W-1:0];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACC: begin
                    if (in_valid) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        if (last_term) begin
                            state_q     <= ST_OUT;
                            out_data_q  <= out_d;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_ACC;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Gated by reset so nothing is accepted while the block is held in reset.
    assign in_ready  = ap_rst_n && (state_q != ST_OUT);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cnn_conv_acc.sv
// Self-checking bench for cnn_conv_acc: vector table, scoreboard queue, model-checked
// random groups, plus hand-written backpressure and reset sequences.
module tb_cnn_conv_acc;

    localparam int PROD_W  = 22;
    localparam int BIAS_W  = 16;
    localparam int N_TERMS = 9;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic [PROD_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [BIAS_W-1:0] bias = '0;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              busy;

    int checks = 0;
    int fails  = 0;
    int sb[$];
    int mon_exp;
    int prods[N_TERMS];

    typedef struct {
        int bias;
        int prod;
        int gaps;
        int exp;
    } vec_t;

    vec_t vecs[10];

    cnn_conv_acc dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bias      (bias),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Scoreboard: a transfer is pending at the next rising edge when both are high here.
    always @(negedge ap_clk) begin
        if (ap_rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_output: got %0d, expected no output", $signed(out_data));
            end else begin
                mon_exp = sb.pop_front();
                $display("output transfer: out_data=%0d expected=%0d", $signed(out_data), mon_exp);
                check("out_data", int'($signed(out_data)), mon_exp);
            end
        end
    end

    function automatic int model(input longint acc);
        longint q;
        if (acc < 0) acc = 0;
        q = (acc + 128) / 256;
        if (q > 127) q = 127;
        return int'(q);
    endfunction

    task automatic send(input int p, input int b);
        int  budget;
        bit  ok;
        in_data  = PROD_W'(p);
        bias     = BIAS_W'(b);
        in_valid = 1'b1;
        budget   = 50;
        ok       = 1'b0;
        while (!ok && budget > 0) begin
            @(negedge ap_clk);
            ok = in_ready;
            @(posedge ap_clk);
            #1;
            budget--;
        end
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL in_ready_timeout: got in_ready=0 for 50 cycles, expected 1");
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 40;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge ap_clk);
            budget--;
        end
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
        @(posedge ap_clk);
        #1;
    endtask

    // Bias only matters on the first term; later terms carry junk on the bias port.
    task automatic send_terms(input int b, input int gaps);
        for (int i = 0; i < N_TERMS; i++) begin
            if (i > 0) begin
                repeat (gaps) begin
                    @(posedge ap_clk);
                    #1;
                end
            end
            send(prods[i], (i == 0) ? b : int'($urandom_range(0, 65535)));
        end
    endtask

    task automatic run_group(input int b, input int gaps, input int exp);
        sb.push_back(exp);
        send_terms(b, gaps);
        @(negedge ap_clk);
        check("latency_out_valid", int'(out_valid), 1);
        wait_drain();
    endtask

    initial begin
        int  hold;
        longint acc;

        vecs[0] = '{bias: 0,    prod: 100,     gaps: 0, exp: 4};
        vecs[1] = '{bias: 0,    prod: -1000,   gaps: 1, exp: 0};
        vecs[2] = '{bias: 127,  prod: 0,       gaps: 0, exp: 0};
        vecs[3] = '{bias: 128,  prod: 0,       gaps: 2, exp: 1};
        vecs[4] = '{bias: 0,    prod: 2097151, gaps: 0, exp: 127};
        vecs[5] = '{bias: -200, prod: 50,      gaps: 3, exp: 1};
        vecs[6] = '{bias: 0,    prod: 3584,    gaps: 0, exp: 126};
        vecs[7] = '{bias: 0,    prod: 3626,    gaps: 1, exp: 127};
        vecs[8] = '{bias: -1,   prod: 0,       gaps: 0, exp: 0};
        vecs[9] = '{bias: 0,    prod: 15,      gaps: 0, exp: 1};

        #1;
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        check("post_reset_in_ready", int'(in_ready), 1);

        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < N_TERMS; i++) prods[i] = vecs[v].prod;
            run_group(vecs[v].bias, vecs[v].gaps, vecs[v].exp);
        end

        for (int g = 0; g < 6; g++) begin
            int b;
            b   = int'($urandom_range(0, 8000)) - 4000;
            acc = longint'(b);
            for (int i = 0; i < N_TERMS; i++) begin
                prods[i] = int'($urandom_range(0, 40000)) - 20000;
                acc += longint'(prods[i]);
            end
            run_group(b, g % 3, model(acc));
        end

        // Backpressure: result must hold while in_valid toggles and nothing is consumed.
        out_ready = 1'b0;
        for (int i = 0; i < N_TERMS; i++) prods[i] = 100;
        sb.push_back(4);
        send_terms(0, 0);
        @(negedge ap_clk);
        check("bp_out_valid_rise", int'(out_valid), 1);
        hold = int'(out_data);
        @(posedge ap_clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0);
            in_data  = PROD_W'(5000);
            @(negedge ap_clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_data", int'(out_data), hold);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_busy", int'(busy), 1);
            @(posedge ap_clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        for (int i = 0; i < N_TERMS; i++) prods[i] = 256;
        run_group(0, 0, 9);

        // Reset after four of nine terms, asserted between clock edges.
        for (int i = 0; i < 4; i++) send(1000, 0);
        check("mid_group_busy", int'(busy), 1);
        #3;
        ap_rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", int'(out_valid), 0);
        check("async_rst_out_data", int'(out_data), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_in_ready", int'(in_ready), 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        check("rst_release_in_ready", int'(in_ready), 1);
        check("rst_release_busy", int'(busy), 0);
        for (int i = 0; i < N_TERMS; i++) prods[i] = 256;
        run_group(0, 1, 9);

        repeat (3) @(posedge ap_clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/cnn_conv_acc.md
CNN_CONV_ACC -- requirements
Module: cnn_conv_acc

Interface
REQ-001 SHALL have parameter PROD_W, default 22, giving the signed product width from the 8s x 14s multiplier.
REQ-002 SHALL have parameter BIAS_W, default 16, giving the signed bias width, already at accumulator scale.
REQ-003 SHALL have parameter ACC_W, default 32, giving the signed accumulator width.
REQ-004 SHALL have parameter N_TERMS, default 9, giving the number of products per output; legal range 1..1023.
REQ-005 SHALL have parameter SHIFT, default 8, giving the requantization right-shift; legal range 1..16.
REQ-006 SHALL have parameter OUT_W, default 8, giving the signed output width.
REQ-007 SHALL have port ap_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-009 SHALL have port in_data, input, PROD_W bits: signed product.
REQ-010 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-011 SHALL have port in_ready, output, 1 bit: block accepts in_data.
REQ-012 SHALL have port bias, input, BIAS_W bits: signed bias, sampled with the first term of each group.
REQ-013 SHALL have port out_data, output, OUT_W bits: signed requantized activation.
REQ-014 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-016 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-017 Input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-018 The FSM SHALL have three states: IDLE, ACC and OUT; in_ready=1 in IDLE and ACC, in_ready=0 in OUT.
REQ-019 In IDLE, an input transfer SHALL load acc = sext(bias) + sext(in_data) and cnt = 1, then go to ACC, or go to OUT if N_TERMS = 1.
REQ-020 In ACC, each input transfer SHALL do acc += sext(in_data) and cnt += 1; the transfer with cnt = N_TERMS-1 SHALL move the FSM to OUT.
REQ-021 Accumulation SHALL be two's-complement at ACC_W; the parameter ranges guarantee no overflow, and no saturation logic is required on acc.
REQ-022 Requantization SHALL apply, in this order:
- r = (acc < 0) ? 0 : acc (ReLU);
- q = (r + 2^(SHIFT-1)) >> SHIFT (round half up);
- out = min(q, 2^(OUT_W-1)-1) (saturate; 127 by default).
REQ-023 out_data SHALL be registered; it is loaded on the edge that enters OUT and held stable, with out_valid=1, until the output transfer.
REQ-024 Latency SHALL be one cycle: out_valid rises on the cycle after the last input transfer.
REQ-025 The output transfer SHALL return the FSM to IDLE and clear out_valid on the same edge; the next group can start on the following cycle, so sustained throughput is N_TERMS+1 cycles per output.
REQ-026 in_valid in OUT SHALL be ignored; no data is consumed and cnt and acc are unchanged.
REQ-027 in_valid=0 in ACC SHALL stall accumulation indefinitely with state held; gaps SHALL NOT affect the result.
REQ-028 out_ready SHALL be ignored outside OUT.
REQ-029 busy SHALL equal (state != IDLE).

Reset
REQ-030 Asserting ap_rst_n=0 SHALL immediately, without waiting for a clock, force state=IDLE, acc=0, cnt=0, out_data=0 and out_valid=0.
REQ-031 While ap_rst_n=0, in_ready SHALL be 0 and busy SHALL be 0; in_ready SHALL become 1 on the first cycle after deassertion.
REQ-032 Reset mid-group SHALL discard the partial sum, with no output emitted for that group.

Verification
REQ-033 Reset: ap_rst_n low mid-ACC with no clock edge -> out_valid=0, out_data=0 and busy=0 at once; after release, in_ready=1.
REQ-034 Defaults, bias=0, nine products of 100 (acc=900) -> one cycle after the 9th transfer, out_valid=1 and out_data=4.
REQ-035 ReLU and rounding:
- nine products of -1000 -> out_data=0;
- nine products of 0 with bias=127 -> out_data=0;
- nine products of 0 with bias=128 -> out_data=1.
REQ-036 Saturation: nine products of 2097151 with bias=0 -> out_data=127.
REQ-037 Backpressure: out_ready low for 5 cycles while in_valid toggles -> out_valid and out_data stable, in_ready=0, no input consumed; with out_ready=1, the next group result is correct.
REQ-038 Reset after 4 of 9 terms, then a full group of nine products of 256 with bias=0 -> out_data=9, with no residue from the aborted group.
